dual_issue_ctrl: RTL and testbench
==================================

Name: dual_issue_ctrl

Overview:
- Issue-side controller for the dual-issue MIPS pipeline. Sits between decode slots ds1/ds2 and execute lanes es1/es2.
- Checks the decoded pair for intra-pair hazards and structural conflicts. Drives the per-lane execute clock-enables and payload registers.
- Splits a conflicting pair over two cycles and back-pressures decode while doing so.
- Its es1_o_ce/es2_o_ce outputs are the lane enables that downstream enable gating consumes.

Parameters:
- PW, 32, width of the per-slot opaque instruction payload passed to execute.
- RW, 5, register index width.
- CW, 16, width of the split-event performance counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- ds1_valid  in  1  slot 1 holds a valid instruction
- ds1_payload  in  PW  slot 1 payload
- ds1_rd  in  RW  slot 1 destination register
- ds1_we  in  1  slot 1 writes rd
- ds1_mem  in  1  slot 1 is a load/store
- ds2_valid  in  1  slot 2 holds a valid instruction
- ds2_payload  in  PW  slot 2 payload
- ds2_rs  in  RW  slot 2 source register rs
- ds2_rt  in  RW  slot 2 source register rt
- ds2_rt_used  in  1  slot 2 reads rt
- ds2_rd  in  RW  slot 2 destination register
- ds2_we  in  1  slot 2 writes rd
- ds2_mem  in  1  slot 2 is a load/store
- i_es_stall  in  1  execute cannot accept; hold issue registers
- i_flush  in  1  branch/exception flush
- es1_o_ce  out  1  lane 1 execute enable (registered)
- es2_o_ce  out  1  lane 2 execute enable (registered)
- es1_payload  out  PW  lane 1 payload (registered)
- es2_payload  out  PW  lane 2 payload (registered)
- o_ds_stall  out  1  decode must hold its current pair (combinational)
- o_split_cnt  out  CW  saturating count of split pairs

Behaviour:
- Reset (async, i_rst=1): state=ISSUE; es1_o_ce=0, es2_o_ce=0; both payloads=0; hold register cleared; o_split_cnt=0. o_ds_stall=0 while in reset.
- Lane mapping is fixed: slot1 to lane1, slot2 to lane2. No swapping.
- Latency: one cycle from decode inputs to es* registers.
- conflict, combinational, evaluated only when both slots are valid. It is true on any of:
  - RAW: ds1_we & ds1_rd!=0 & (ds1_rd==ds2_rs | (ds2_rt_used & ds1_rd==ds2_rt)).
  - WAW: ds1_we & ds2_we & ds1_rd!=0 & ds1_rd==ds2_rd.
  - Structural: ds1_mem & ds2_mem. There is one memory port.
- Register 0 never causes a hazard.
- State ISSUE, when i_es_stall=0:
  - No conflict: es1_o_ce=ds1_valid, es2_o_ce=ds2_valid. Payloads are loaded from the slots; the payload of an invalid slot is don't-care but must be loaded as 0. Stay in ISSUE.
  - Conflict: es1_o_ce=1 with ds1_payload; es2_o_ce=0. ds2_payload goes into the hold register. Increment o_split_cnt, saturating at all-ones. Go to SPLIT.
- State SPLIT, when i_es_stall=0: es1_o_ce=0; es2_o_ce=1 with es2_payload=hold. Go to ISSUE. Decode inputs are ignored in this cycle.
- o_ds_stall = (state==SPLIT) | i_es_stall.
- i_es_stall=1: all es* registers, the hold register, state and counter keep their values. Stall has priority over normal issue.
- i_flush=1, synchronous: at the next edge es1_o_ce=es2_o_ce=0, payloads=0, hold cleared, state=ISSUE. The counter keeps its value.
  - Flush overrides i_es_stall and any pending SPLIT; a half-issued split pair is dropped.
- Reset asserted mid-SPLIT returns to ISSUE immediately, with no lane-2 issue.

Decomposition:
- Shared header issue_defs.vh, include-guarded, holds:
  - the state encoding localparams ISSUE=1'b0 and SPLIT=1'b1;
  - the register-0 constant;
  - default widths PW/RW.
- One combinational sub-module, dual_issue_hazard. Inputs are the slot fields; outputs are raw, waw, struct and conflict. It is reused by future forwarding logic.

Test Plan:
- Independent pair: ds1 rd=3 we=1; ds2 rs=4 rt=5 rd=6. Response: next cycle es1_o_ce=1, es2_o_ce=1, payloads match the slots, o_ds_stall=0, counter=0.
- RAW split: ds1 rd=8 we=1; ds2 rs=8. Response:
  - cycle 1: es1=1, es2=0, o_ds_stall=1.
  - cycle 2: es1=0, es2=1, es2_payload=ds2 payload.
  - cycle 3: back to ISSUE; counter=1.
- Register 0 and rt_used: ds1 rd=0 we=1 with ds2 rs=0 gives no split. ds1 rd=7 with ds2 rt=7 and rt_used=0 gives no split. ds1 rd=7 with ds2 rt=7 and rt_used=1 splits.
- Structural, plus stall during SPLIT: both slots mem=1, so the pair splits. Assert i_es_stall for 2 cycles while in SPLIT. Response: outputs frozen, o_ds_stall=1 throughout, and lane-2 issue occurs the cycle after the stall drops.
- Flush in SPLIT: i_flush=1 in the SPLIT cycle. Response: next edge es1=es2=0, state ISSUE, the held instruction is never issued, counter unchanged.
- Counter saturation and reset: with CW=4, run 17 splits; o_split_cnt stays at 15. Assert i_rst asynchronously between clock edges: all outputs go to 0 immediately.

Source files
------------

// File: rtl/dual_issue_ctrl_pkg.sv
// Shared definitions for the dual-issue controller: state encoding,
// the hardwired-zero register index and default widths.
package dual_issue_ctrl_pkg;

  typedef enum logic {
    ISSUE = 1'b0,
    SPLIT = 1'b1
  } issue_state_e;

  localparam int REG_ZERO = 0;

  localparam int DEF_PW = 32;
  localparam int DEF_RW = 5;
  localparam int DEF_CW = 16;

endpackage

// File: rtl/dual_issue_ctrl_if.sv
// Decode-to-execute bundle for the dual-issue controller.
// The master drives the decode slots and execute status; the slave issues.
interface dual_issue_ctrl_if
  import dual_issue_ctrl_pkg::*;
#(
  parameter int PW = DEF_PW,
  parameter int RW = DEF_RW,
  parameter int CW = DEF_CW
);

  logic          ds1_valid;
  logic [PW-1:0] ds1_payload;
  logic [RW-1:0] ds1_rd;
  logic          ds1_we;
  logic          ds1_mem;

  logic          ds2_valid;
  logic [PW-1:0] ds2_payload;
  logic [RW-1:0] ds2_rs;
  logic [RW-1:0] ds2_rt;
  logic          ds2_rt_used;
  logic [RW-1:0] ds2_rd;
  logic          ds2_we;
  logic          ds2_mem;

  logic          i_es_stall;
  logic          i_flush;

  logic          es1_o_ce;
  logic          es2_o_ce;
  logic [PW-1:0] es1_payload;
  logic [PW-1:0] es2_payload;
  logic          o_ds_stall;
  logic [CW-1:0] o_split_cnt;

  modport master (
    output ds1_valid, ds1_payload, ds1_rd, ds1_we, ds1_mem,
    output ds2_valid, ds2_payload, ds2_rs, ds2_rt, ds2_rt_used,
    output ds2_rd, ds2_we, ds2_mem,
    output i_es_stall, i_flush,
    input  es1_o_ce, es2_o_ce, es1_payload, es2_payload,
    input  o_ds_stall, o_split_cnt
  );

  modport slave (
    input  ds1_valid, ds1_payload, ds1_rd, ds1_we, ds1_mem,
    input  ds2_valid, ds2_payload, ds2_rs, ds2_rt, ds2_rt_used,
    input  ds2_rd, ds2_we, ds2_mem,
    input  i_es_stall, i_flush,
    output es1_o_ce, es2_o_ce, es1_payload, es2_payload,
    output o_ds_stall, o_split_cnt
  );

endinterface

// File: rtl/dual_issue_ctrl_hazard.sv
// Intra-pair hazard detection between decode slot 1 and slot 2.
// Purely combinational so forwarding logic can reuse the individual terms.
module dual_issue_hazard
  import dual_issue_ctrl_pkg::*;
#(
  parameter int RW = DEF_RW
) (
  input  logic          ds1_valid,
  input  logic [RW-1:0] ds1_rd,
  input  logic          ds1_we,
  input  logic          ds1_mem,
  input  logic          ds2_valid,
  input  logic [RW-1:0] ds2_rs,
  input  logic [RW-1:0] ds2_rt,
  input  logic          ds2_rt_used,
  input  logic [RW-1:0] ds2_rd,
  input  logic          ds2_we,
  input  logic          ds2_mem,
  output logic          raw,
  output logic          waw,
  output logic          structural,
  output logic          conflict
);

  localparam logic [RW-1:0] R0 = RW'(REG_ZERO);

  // Writes to r0 are discarded, so they can never create a dependency.
  logic ds1_writes;
  assign ds1_writes = ds1_we && (ds1_rd != R0);

  assign raw        = ds1_writes &&
                      ((ds1_rd == ds2_rs) || (ds2_rt_used && (ds1_rd == ds2_rt)));
  assign waw        = ds1_writes && ds2_we && (ds1_rd == ds2_rd);
  assign structural = ds1_mem && ds2_mem;
  assign conflict   = ds1_valid && ds2_valid && (raw || waw || structural);

endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue controller: maps decode slots onto execute lanes and splits
// conflicting pairs over two cycles while holding decode.
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int PW = DEF_PW,
  parameter int RW = DEF_RW,
  parameter int CW = DEF_CW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  dual_issue_ctrl_if.slave bus
);

  issue_state_e  state;
  logic [PW-1:0] hold;
  logic          es1_ce;
  logic          es2_ce;
  logic [PW-1:0] es1_pl;
  logic [PW-1:0] es2_pl;
  logic [CW-1:0] split_cnt;

  logic hz_raw;
  logic hz_waw;
  logic hz_struct;
  logic hz_conflict;

  dual_issue_hazard #(.RW(RW)) u_hazard (
    .ds1_valid   (bus.ds1_valid),
    .ds1_rd      (bus.ds1_rd),
    .ds1_we      (bus.ds1_we),
    .ds1_mem     (bus.ds1_mem),
    .ds2_valid   (bus.ds2_valid),
    .ds2_rs      (bus.ds2_rs),
    .ds2_rt      (bus.ds2_rt),
    .ds2_rt_used (bus.ds2_rt_used),
    .ds2_rd      (bus.ds2_rd),
    .ds2_we      (bus.ds2_we),
    .ds2_mem     (bus.ds2_mem),
    .raw         (hz_raw),
    .waw         (hz_waw),
    .structural  (hz_struct),
    .conflict    (hz_conflict)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ISSUE;
      hold      <= '0;
      es1_ce    <= 1'b0;
      es2_ce    <= 1'b0;
      es1_pl    <= '0;
      es2_pl    <= '0;
      split_cnt <= '0;
    end else if (bus.i_flush) begin
      // A half-issued split pair is dropped; the counter keeps its history.
      state  <= ISSUE;
      hold   <= '0;
      es1_ce <= 1'b0;
      es2_ce <= 1'b0;
      es1_pl <= '0;
      es2_pl <= '0;
    end else if (!bus.i_es_stall) begin
      case (state)
        ISSUE: begin
          if (hz_conflict) begin
            es1_ce <= 1'b1;
            es1_pl <= bus.ds1_payload;
            es2_ce <= 1'b0;
            es2_pl <= '0;
            hold   <= bus.ds2_payload;
            if (split_cnt != {CW{1'b1}}) split_cnt <= split_cnt + CW'(1);
            state  <= SPLIT;
          end else begin
            es1_ce <= bus.ds1_valid;
            es2_ce <= bus.ds2_valid;
            es1_pl <= bus.ds1_valid ? bus.ds1_payload : '0;
            es2_pl <= bus.ds2_valid ? bus.ds2_payload : '0;
          end
        end
        SPLIT: begin
          // Second half of a split pair; decode is held so its inputs are ignored.
          es1_ce <= 1'b0;
          es1_pl <= '0;
          es2_ce <= 1'b1;
          es2_pl <= hold;
          hold   <= '0;
          state  <= ISSUE;
        end
        default: state <= ISSUE;
      endcase
    end
  end

  assign bus.es1_o_ce    = es1_ce;
  assign bus.es2_o_ce    = es2_ce;
  assign bus.es1_payload = es1_pl;
  assign bus.es2_payload = es2_pl;
  assign bus.o_split_cnt = split_cnt;
  assign bus.o_ds_stall  = !i_rst && ((state == SPLIT) || bus.i_es_stall);

  a_conflict_cause : assert property (
    @(posedge i_clk) disable iff (i_rst) hz_conflict |-> (hz_raw || hz_waw || hz_struct)
  );

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed bench for dual_issue_ctrl: a vector table of single pairs plus
// hand-written sequences for stall, flush, saturation and async reset.
module tb_dual_issue_ctrl;
  localparam int PW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dual_issue_ctrl_if #(.PW(PW), .RW(RW), .CW(CW)) bus ();
  dual_issue_ctrl #(.PW(PW), .RW(RW), .CW(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    string         name;
    logic          v1;
    logic [RW-1:0] rd1;
    logic          we1;
    logic          mem1;
    logic [PW-1:0] p1;
    logic          v2;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rt2;
    logic          rtu2;
    logic [RW-1:0] rd2;
    logic          we2;
    logic          mem2;
    logic [PW-1:0] p2;
    logic          split;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  task automatic check(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.ds1_valid   = v.v1;
    bus.ds1_payload = v.p1;
    bus.ds1_rd      = v.rd1;
    bus.ds1_we      = v.we1;
    bus.ds1_mem     = v.mem1;
    bus.ds2_valid   = v.v2;
    bus.ds2_payload = v.p2;
    bus.ds2_rs      = v.rs2;
    bus.ds2_rt      = v.rt2;
    bus.ds2_rt_used = v.rtu2;
    bus.ds2_rd      = v.rd2;
    bus.ds2_we      = v.we2;
    bus.ds2_mem     = v.mem2;
  endtask

  task automatic idle();
    vec_t v;
    v = '{"idle", 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0};
    drive(v);
  endtask

  task automatic bump();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " es1_ce"},  {31'd0, bus.es1_o_ce}, 32'd0);
    check({nm, " es2_ce"},  {31'd0, bus.es2_o_ce}, 32'd0);
    check({nm, " es1_pl"},  bus.es1_payload, 32'd0);
    check({nm, " es2_pl"},  bus.es2_payload, 32'd0);
    check({nm, " ds_stall"}, {31'd0, bus.o_ds_stall}, 32'd0);
  endtask

  task automatic apply_vec(input vec_t v);
    drive(v);
    tick();
    if (!v.split) begin
      check({v.name, " es1_ce"},  {31'd0, bus.es1_o_ce}, {31'd0, v.v1});
      check({v.name, " es2_ce"},  {31'd0, bus.es2_o_ce}, {31'd0, v.v2});
      check({v.name, " es1_pl"},  bus.es1_payload, v.v1 ? v.p1 : 32'd0);
      check({v.name, " es2_pl"},  bus.es2_payload, v.v2 ? v.p2 : 32'd0);
      check({v.name, " ds_stall"}, {31'd0, bus.o_ds_stall}, 32'd0);
      check({v.name, " cnt"},     {28'd0, bus.o_split_cnt}, 32'(exp_cnt));
    end else begin
      bump();
      check({v.name, " c1 es1_ce"},  {31'd0, bus.es1_o_ce}, 32'd1);
      check({v.name, " c1 es2_ce"},  {31'd0, bus.es2_o_ce}, 32'd0);
      check({v.name, " c1 es1_pl"},  bus.es1_payload, v.p1);
      check({v.name, " c1 ds_stall"}, {31'd0, bus.o_ds_stall}, 32'd1);
      check({v.name, " c1 cnt"},     {28'd0, bus.o_split_cnt}, 32'(exp_cnt));
      idle();
      tick();
      check({v.name, " c2 es1_ce"},  {31'd0, bus.es1_o_ce}, 32'd0);
      check({v.name, " c2 es2_ce"},  {31'd0, bus.es2_o_ce}, 32'd1);
      check({v.name, " c2 es2_pl"},  bus.es2_payload, v.p2);
      check({v.name, " c2 ds_stall"}, {31'd0, bus.o_ds_stall}, 32'd0);
    end
  endtask

  vec_t vecs[12];
  vec_t raw_v;
  vec_t mem_v;

  initial begin
    //          name         v1  rd1  we1 mem1 p1            v2  rs2  rt2 rtu rd2  we2 mem2 p2            split
    vecs[0]  = '{"indep",    1, 5'd3, 1, 0, 32'h1111_0001, 1, 5'd4, 5'd5, 1, 5'd6, 1, 0, 32'h2222_0001, 0};
    vecs[1]  = '{"raw_rs",   1, 5'd8, 1, 0, 32'h1111_0002, 1, 5'd8, 5'd1, 0, 5'd2, 1, 0, 32'h2222_0002, 1};
    vecs[2]  = '{"r0",       1, 5'd0, 1, 0, 32'h1111_0003, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 32'h2222_0003, 0};
    vecs[3]  = '{"rt_unused",1, 5'd7, 1, 0, 32'h1111_0004, 1, 5'd1, 5'd7, 0, 5'd2, 1, 0, 32'h2222_0004, 0};
    vecs[4]  = '{"rt_used",  1, 5'd7, 1, 0, 32'h1111_0005, 1, 5'd1, 5'd7, 1, 5'd2, 1, 0, 32'h2222_0005, 1};
    vecs[5]  = '{"waw",      1, 5'd9, 1, 0, 32'h1111_0006, 1, 5'd1, 5'd2, 1, 5'd9, 1, 0, 32'h2222_0006, 1};
    vecs[6]  = '{"no_we",    1, 5'd9, 0, 0, 32'h1111_0007, 1, 5'd9, 5'd9, 1, 5'd9, 1, 0, 32'h2222_0007, 0};
    vecs[7]  = '{"struct",   1, 5'd3, 1, 1, 32'h1111_0008, 1, 5'd4, 5'd5, 1, 5'd6, 1, 1, 32'h2222_0008, 1};
    vecs[8]  = '{"one_mem",  1, 5'd3, 1, 1, 32'h1111_0009, 1, 5'd4, 5'd5, 1, 5'd6, 1, 0, 32'h2222_0009, 0};
    vecs[9]  = '{"ds2_inv",  1, 5'd8, 1, 1, 32'h1111_000A, 0, 5'd8, 5'd8, 1, 5'd8, 1, 1, 32'h2222_000A, 0};
    vecs[10] = '{"ds1_inv",  0, 5'd8, 1, 1, 32'h1111_000B, 1, 5'd8, 5'd8, 1, 5'd8, 1, 1, 32'h2222_000B, 0};
    vecs[11] = '{"none",     0, 5'd3, 1, 0, 32'h1111_000C, 0, 5'd4, 5'd5, 1, 5'd6, 1, 0, 32'h2222_000C, 0};

    raw_v = '{"raw",    1, 5'd8, 1, 0, 32'hAAAA_0001, 1, 5'd8, 5'd0, 0, 5'd1, 1, 0, 32'hBBBB_0001, 1};
    mem_v = '{"memseq", 1, 5'd3, 1, 1, 32'hAAAA_0002, 1, 5'd4, 5'd5, 1, 5'd6, 0, 1, 32'hBBBB_0002, 1};

    rst = 1'b1;
    bus.i_es_stall = 1'b0;
    bus.i_flush    = 1'b0;
    idle();
    #2;
    check_all_zero("reset");
    check("reset cnt", {28'd0, bus.o_split_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) apply_vec(vecs[i]);

    // Stall while in SPLIT: everything frozen, lane 2 issues after release.
    drive(mem_v);
    tick();
    bump();
    check("stl c1 es1_ce", {31'd0, bus.es1_o_ce}, 32'd1);
    check("stl c1 es2_ce", {31'd0, bus.es2_o_ce}, 32'd0);
    bus.i_es_stall = 1'b1;
    drive(vecs[0]);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stl hold es1_ce", {31'd0, bus.es1_o_ce}, 32'd1);
      check("stl hold es2_ce", {31'd0, bus.es2_o_ce}, 32'd0);
      check("stl hold es1_pl", bus.es1_payload, mem_v.p1);
      check("stl hold ds_stall", {31'd0, bus.o_ds_stall}, 32'd1);
      check("stl hold cnt", {28'd0, bus.o_split_cnt}, 32'(exp_cnt));
    end
    bus.i_es_stall = 1'b0;
    idle();
    #1;
    check("stl split ds_stall", {31'd0, bus.o_ds_stall}, 32'd1);
    tick();
    check("stl c2 es1_ce", {31'd0, bus.es1_o_ce}, 32'd0);
    check("stl c2 es2_ce", {31'd0, bus.es2_o_ce}, 32'd1);
    check("stl c2 es2_pl", bus.es2_payload, mem_v.p2);
    check("stl c2 ds_stall", {31'd0, bus.o_ds_stall}, 32'd0);

    // Stall in ISSUE holds the last issue.
    bus.i_es_stall = 1'b1;
    drive(vecs[0]);
    tick();
    check("stl issue es2_ce", {31'd0, bus.es2_o_ce}, 32'd1);
    check("stl issue es1_ce", {31'd0, bus.es1_o_ce}, 32'd0);
    check("stl issue es2_pl", bus.es2_payload, mem_v.p2);
    bus.i_es_stall = 1'b0;
    idle();
    tick();

    // Flush in SPLIT (together with stall): held instruction is dropped.
    drive(raw_v);
    tick();
    bump();
    check("fl c1 es1_ce", {31'd0, bus.es1_o_ce}, 32'd1);
    bus.i_flush = 1'b1;
    bus.i_es_stall = 1'b1;
    idle();
    tick();
    bus.i_flush = 1'b0;
    bus.i_es_stall = 1'b0;
    #1;
    check_all_zero("flush");
    check("flush cnt", {28'd0, bus.o_split_cnt}, 32'(exp_cnt));
    tick();
    check("flush after es2_ce", {31'd0, bus.es2_o_ce}, 32'd0);
    check("flush after es2_pl", bus.es2_payload, 32'd0);
    check("flush after cnt", {28'd0, bus.o_split_cnt}, 32'(exp_cnt));

    // Saturation.
    for (int k = 0; k < 17; k++) begin
      drive(raw_v);
      tick();
      bump();
      idle();
      tick();
    end
    check("sat cnt", {28'd0, bus.o_split_cnt}, 32'd15);
    check("sat es2_pl", bus.es2_payload, raw_v.p2);

    // Async reset mid-SPLIT, with stall high, between edges.
    drive(raw_v);
    tick();
    check("rst pre es1_ce", {31'd0, bus.es1_o_ce}, 32'd1);
    bus.i_es_stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async rst");
    check("async rst cnt", {28'd0, bus.o_split_cnt}, 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.i_es_stall = 1'b0;
    idle();
    tick();
    check("post rst es2_ce", {31'd0, bus.es2_o_ce}, 32'd0);
    check("post rst es2_pl", bus.es2_payload, 32'd0);
    check("post rst cnt", {28'd0, bus.o_split_cnt}, 32'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
